// File: rtl/audio_frame_serializer.sv
// Packs multichannel microphone samples into byte frames (A5, seq, channel bytes) for a UART.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte covering seq through the last data byte.
module audio_frame_serializer #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned OUT_BYTES    = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] samples_in,
  input  logic                             sample_valid_in,
  input  logic                             enable_in,
  input  logic                             uart_busy_in,
  output logic [7:0]                       byte_out,
  output logic                             byte_valid_out,
  output logic                             busy_out,
  output logic [7:0]                       overflow_count_out
);

  localparam int unsigned PadW  = ((SAMPLE_WIDTH + 7) / 8) * 8;
  localparam int unsigned ChW   = 8 * OUT_BYTES;
  localparam int unsigned DataW = CHANNELS * ChW;
`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned NumBytes = 3 + CHANNELS * OUT_BYTES;
`else
  localparam int unsigned NumBytes = 2 + CHANNELS * OUT_BYTES;
`endif
  localparam int unsigned FrameW = 8 * NumBytes;
  localparam int unsigned CntW   = $clog2(NumBytes + 1);

  typedef enum logic [1:0] {StIdle, StSend, StGuard} state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [FrameW-1:0]   pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          seq_q, seq_d;
  logic [7:0]          ovf_q, ovf_d;
  logic [7:0]          byte_q, byte_d;
  logic                bv_q, bv_d;
  logic                valid_q;
  logic                edge_det;
  logic [DataW-1:0]    data_bits;
  logic [FrameW-1:0]   new_frame;

  // Left-justify into whole bytes, then keep the top OUT_BYTES bytes.
  function automatic logic [ChW-1:0] chan_bytes(input logic [SAMPLE_WIDTH-1:0] s);
    logic [PadW-1:0] padded;
    padded = PadW'(s) << (PadW - SAMPLE_WIDTH);
    return padded[PadW-1 -: ChW];
  endfunction

  always_comb begin
    data_bits = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      data_bits[DataW-1-k*ChW -: ChW] = chan_bytes(samples_in[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = seq_q;
    for (int unsigned i = 0; i < CHANNELS * OUT_BYTES; i++) begin
      csum = csum ^ data_bits[8*i +: 8];
    end
  end
  assign new_frame = {8'hA5, seq_q, data_bits, csum};
`else
  assign new_frame = {8'hA5, seq_q, data_bits};
`endif

  assign edge_det = sample_valid_in & ~valid_q;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    ovf_d      = ovf_q;
    byte_d     = byte_q;
    bv_d       = 1'b0;
    unique case (state_q)
      StSend: begin
        if (!uart_busy_in) begin
          byte_d  = frame_q[FrameW-1 -: 8];
          bv_d    = 1'b1;
          frame_d = frame_q << 8;
          cnt_d   = cnt_q - 1'b1;
          state_d = StGuard;
        end
      end
      StGuard: begin
        if (cnt_q != '0) begin
          state_d = StSend;
        end else if (pend_vld_q) begin
          frame_d    = pend_q;
          cnt_d      = CntW'(NumBytes);
          pend_vld_d = 1'b0;
          state_d    = StSend;
        end else begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase
    // Evaluated after completion so a just-freed slot can take this edge.
    if (edge_det && enable_in) begin
      seq_d = seq_q + 8'd1;
      if (state_d == StIdle) begin
        frame_d = new_frame;
        cnt_d   = CntW'(NumBytes);
        state_d = StSend;
      end else if (!pend_vld_d) begin
        pend_d     = new_frame;
        pend_vld_d = 1'b1;
      end else if (ovf_q != 8'hFF) begin
        ovf_d = ovf_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      seq_q      <= 8'h00;
      ovf_q      <= 8'h00;
      byte_q     <= 8'h00;
      bv_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
      byte_q     <= byte_d;
      bv_q       <= bv_d;
      valid_q    <= sample_valid_in;
    end
  end

  assign byte_out           = byte_q;
  assign byte_valid_out     = bv_q;
  assign busy_out           = (state_q != StIdle) || pend_vld_q;
  assign overflow_count_out = ovf_q;

endmodule

// File: tb/tb_audio_frame_serializer.sv
// Self-checking bench for audio_frame_serializer: directed scenarios plus randomized traffic
// against a frame-queue reference model; a second 12-bit instance checks byte padding.
module tb_audio_frame_serializer;

  localparam int TB_CH  = 2;
  localparam int TB_SW  = 24;
  localparam int TB_OB  = 2;
  localparam int TB_PAD = ((TB_SW + 7) / 8) * 8;
  localparam int SMP_W  = TB_CH * TB_SW;
`ifdef FRAME_CHECKSUM_EN
  localparam int TB_LEN = 3 + TB_CH * TB_OB;
`else
  localparam int TB_LEN = 2 + TB_CH * TB_OB;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SMP_W-1:0] smp = '0;
  logic             svi = 1'b0;
  logic             en = 1'b1;
  logic             uart_busy = 1'b0;
  logic [7:0]       byte_out;
  logic             bv_out;
  logic             busy_out;
  logic [7:0]       ovf_out;

  logic [23:0]      smp12 = {12'h000, 12'hABC};
  logic             svi12 = 1'b0;
  logic [7:0]       byte12;
  logic             bv12;
  logic             busy12;
  logic [7:0]       ovf12;

  always #5 clk = ~clk;

  audio_frame_serializer #(.CHANNELS(2), .SAMPLE_WIDTH(24), .OUT_BYTES(2)) u_dut (
    .clk_in(clk), .rst_in(rst), .samples_in(smp), .sample_valid_in(svi), .enable_in(en),
    .uart_busy_in(uart_busy), .byte_out(byte_out), .byte_valid_out(bv_out),
    .busy_out(busy_out), .overflow_count_out(ovf_out)
  );

  audio_frame_serializer #(.CHANNELS(2), .SAMPLE_WIDTH(12), .OUT_BYTES(2)) u_dut_w12 (
    .clk_in(clk), .rst_in(rst), .samples_in(smp12), .sample_valid_in(svi12), .enable_in(1'b1),
    .uart_busy_in(1'b0), .byte_out(byte12), .byte_valid_out(bv12),
    .busy_out(busy12), .overflow_count_out(ovf12)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  int unsigned exp_q[$];
  bit          last_q[$];
  int          occ = 0;
  logic [7:0]  m_seq = 8'h00;
  int          m_ovf = 0;
  logic        svi_prev = 1'b0;

  // UART / monitor state
  int          uart_cnt = 0;
  int          uart_max = 2;
  logic        prev_bv = 1'b0;
  int          pulse_cnt = 0;
  int          pos = 0;
  int          start_cyc = 0;
  int unsigned cur_frame[8];
  int unsigned seq_log[$];
  int unsigned q12[$];

  // Next-cycle stimulus, applied by step()
  logic             nx_rst = 1'b1;
  logic             nx_svi = 1'b0;
  logic             nx_en = 1'b1;
  logic             nx_hold = 1'b0;
  logic [SMP_W-1:0] nx_smp = '0;

  always @(negedge clk) if (bv12) q12.push_back(32'(byte12));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [SMP_W-1:0] s);
    int unsigned     b[$];
    longint unsigned v;
    longint unsigned padded;
    int unsigned     cs;
    b.push_back(32'hA5);
    b.push_back(32'(m_seq));
    for (int ch = 0; ch < TB_CH; ch++) begin
      v = 64'(s[ch*TB_SW +: TB_SW]);
      padded = v << (TB_PAD - TB_SW);
      for (int j = 0; j < TB_OB; j++) begin
        b.push_back(32'((padded >> (TB_PAD - 8 * (j + 1))) & 64'hFF));
      end
    end
    cs = 0;
    for (int i = 1; i < b.size(); i++) cs = cs ^ b[i];
`ifdef FRAME_CHECKSUM_EN
    b.push_back(cs);
`endif
    for (int i = 0; i < b.size(); i++) begin
      exp_q.push_back(b[i]);
      last_q.push_back(i == b.size() - 1);
    end
  endtask

  task automatic model_edge(input logic [SMP_W-1:0] s);
    if (occ < 2) begin
      push_frame(s);
      occ++;
    end else if (m_ovf < 255) begin
      m_ovf++;
    end
    m_seq = m_seq + 8'd1;
  endtask

  // One clock: check this cycle's outputs, update the model, apply next inputs.
  task automatic step();
    int unsigned e;
    bit          l;
    @(negedge clk);
    cyc++;
    check_eq("busy_out", 32'(busy_out), 32'(occ > 0));
    check_eq("overflow", 32'(ovf_out), 32'(m_ovf));
    if (bv_out) begin
      pulse_cnt++;
      check_eq("bv_back_to_back", 32'(prev_bv), 0);
      check_eq("bv_while_busy", 32'(uart_busy), 0);
      if (exp_q.size() == 0) begin
        check_eq("spurious_bv", 32'(bv_out), 0);
      end else begin
        e = exp_q.pop_front();
        l = last_q.pop_front();
        check_eq("byte", 32'(byte_out), e);
        if (l) occ--;
      end
      if (pos == 0) start_cyc = cyc;
      if (pos == 1) seq_log.push_back(32'(byte_out));
      cur_frame[pos] = 32'(byte_out);
      pos = (pos + 1 == TB_LEN) ? 0 : pos + 1;
      uart_cnt = (uart_max > 0) ? $urandom_range(0, uart_max) : 0;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
    end
    prev_bv = bv_out;
    rst = nx_rst;
    en  = nx_en;
    smp = nx_smp;
    if (nx_rst) begin
      exp_q.delete();
      last_q.delete();
      occ = 0;
      m_seq = 8'h00;
      m_ovf = 0;
      pos = 0;
      svi_prev = 1'b0;
    end else begin
      if (nx_svi && !svi_prev && nx_en) model_edge(nx_smp);
      svi_prev = nx_svi;
    end
    svi = nx_svi;
    uart_busy = (uart_cnt > 0) || nx_hold;
  endtask

  task automatic drain();
    int n;
    n = 0;
    nx_svi = 1'b0;
    nx_hold = 1'b0;
    step();
    while ((busy_out || exp_q.size() != 0 || uart_cnt != 0) && n < 3000) begin
      step();
      n++;
    end
    check_eq("drain_queue", 32'(exp_q.size()), 0);
    check_eq("drain_busy", 32'(busy_out), 0);
  endtask

  task automatic one_edge(input logic [SMP_W-1:0] s);
    nx_smp = s;
    nx_svi = 1'b1;
    step();
    nx_svi = 1'b0;
  endtask

  task automatic do_reset();
    nx_rst = 1'b1;
    nx_svi = 1'b0;
    step();
    step();
    nx_rst = 1'b0;
    step();
    seq_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edge_cyc, p0, p1, s0, found;
    repeat (3) step();
    nx_rst = 1'b0;
    step();
    check_eq("rst_bv", 32'(bv_out), 0);
    check_eq("rst_byte", 32'(byte_out), 0);
    check_eq("rst_busy", 32'(busy_out), 0);
    check_eq("rst_ovf", 32'(ovf_out), 0);

    // Reference frame and first-byte latency; 12-bit instance fires at the same time
    svi12 = 1'b1;
    one_edge({24'hABCDEF, 24'h123456});
    edge_cyc = cyc;
    drain();
    check_eq("latency", 32'(start_cyc - edge_cyc), 2);
    check_eq("f0_sync", cur_frame[0], 32'hA5);
    check_eq("f0_seq", cur_frame[1], 32'h00);
    check_eq("f0_c0_hi", cur_frame[2], 32'h12);
    check_eq("f0_c0_lo", cur_frame[3], 32'h34);
    check_eq("f0_c1_hi", cur_frame[4], 32'hAB);
    check_eq("f0_c1_lo", cur_frame[5], 32'hCD);
`ifdef FRAME_CHECKSUM_EN
    check_eq("f0_csum", cur_frame[6], 32'h40);
`endif
    if (q12.size() >= 4) begin
      check_eq("w12_hi", q12[2], 32'hAB);
      check_eq("w12_lo", q12[3], 32'hC0);
    end else begin
      check_eq("w12_count", 32'(q12.size()), 32'(TB_LEN));
    end

    // Three edges while the UART is held busy
    do_reset();
    nx_hold = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      one_edge({$urandom, $urandom} & {SMP_W{1'b1}});
      step();
    end
    drain();
    check_eq("hold_ovf", 32'(ovf_out), 1);
    check_eq("hold_frames", 32'(seq_log.size()), 2);
    if (seq_log.size() >= 2) begin
      check_eq("hold_seq0", seq_log[0], 0);
      check_eq("hold_seq1", seq_log[1], 1);
    end
    one_edge(48'h0);
    drain();
    check_eq("hold_next_seq", seq_log[$], 3);

    // Disabled edges are ignored; enable falling mid-frame lets the frame finish
    s0 = int'(seq_log[$]);
    p0 = pulse_cnt;
    nx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      one_edge(48'h5);
      step();
      step();
    end
    check_eq("dis_pulses", 32'(pulse_cnt - p0), 0);
    nx_en = 1'b1;
    one_edge({24'h0F0F0F, 24'hF0F0F0});
    for (int k = 0; k < 200 && pulse_cnt < p0 + 2; k++) step();
    check_eq("midframe_reach", 32'(pulse_cnt >= p0 + 2), 1);
    nx_en = 1'b0;
    drain();
    nx_en = 1'b1;
    check_eq("dis_seq", seq_log[$], 32'((s0 + 1) % 256));
    check_eq("dis_frame_len", 32'(pulse_cnt - p0), 32'(TB_LEN));

    // Reset after the third byte aborts the frame
    p0 = pulse_cnt;
    one_edge({24'h777777, 24'h888888});
    for (int k = 0; k < 200 && pulse_cnt < p0 + 3; k++) step();
    check_eq("rst_reach", 32'(pulse_cnt >= p0 + 3), 1);
    nx_rst = 1'b1;
    step();
    step();
    nx_rst = 1'b0;
    p1 = pulse_cnt;
    repeat (20) step();
    check_eq("rst_abort", 32'(pulse_cnt - p1), 0);
    one_edge({24'h010203, 24'h040506});
    drain();
    check_eq("post_rst_sync", cur_frame[0], 32'hA5);
    check_eq("post_rst_seq", cur_frame[1], 32'h00);

    // 257 spaced edges wrap seq without drops
    uart_max = 0;
    seq_log.delete();
    for (int i = 0; i < 257; i++) begin
      one_edge({$urandom, $urandom} & {SMP_W{1'b1}});
      repeat (15) step();
    end
    drain();
    found = 0;
    for (int i = 0; i + 1 < seq_log.size(); i++) begin
      if (seq_log[i] == 32'hFF && seq_log[i+1] == 32'h00) found = 1;
    end
    check_eq("seq_wrap", 32'(found), 1);
    check_eq("wrap_ovf", 32'(ovf_out), 0);

    // Randomized traffic with UART backpressure and enable toggling
    uart_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) nx_svi = ~nx_svi;
      if (!nx_svi) nx_smp = {$urandom, $urandom} & {SMP_W{1'b1}};
      nx_en = ($urandom_range(0, 9) != 0);
      nx_hold = ($urandom_range(0, 19) < 3);
      step();
    end
    nx_en = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
